// File: rtl/sid_note_sequencer_if.sv
// Host-side bus of the note sequencer: playback control, note-table writes and sid_top voice outputs.
// With SEQ_LOOP_EN defined, a loop request travels alongside start.
interface sid_note_sequencer_if #(
  parameter int AW = 4
);
  logic          start;
  logic          stop;
  logic [AW:0]   num_notes;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
`ifdef SEQ_LOOP_EN
  logic          loop;
`endif
  logic          busy;
  logic          done;
  logic [AW-1:0] note_idx;
  logic [15:0]   frequency;
  logic [7:0]    duration;
  logic [7:0]    attack;
  logic [7:0]    sustain;
  logic [7:0]    waveform;

`ifdef SEQ_LOOP_EN
  modport master (
    output start, stop, num_notes, wr_en, wr_addr, wr_data, loop,
    input  busy, done, note_idx, frequency, duration, attack, sustain, waveform
  );
  modport slave (
    input  start, stop, num_notes, wr_en, wr_addr, wr_data, loop,
    output busy, done, note_idx, frequency, duration, attack, sustain, waveform
  );
`else
  modport master (
    output start, stop, num_notes, wr_en, wr_addr, wr_data,
    input  busy, done, note_idx, frequency, duration, attack, sustain, waveform
  );
  modport slave (
    input  start, stop, num_notes, wr_en, wr_addr, wr_data,
    output busy, done, note_idx, frequency, duration, attack, sustain, waveform
  );
`endif
endinterface

// File: rtl/sid_note_sequencer.sv
// Plays a note table into sid_top voice registers, timing gate-on/gate-off in coarse ticks.
// Build macro SEQ_LOOP_EN: adds a loop request that wraps the last note back to entry 0.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_LOAD     | one cycle: copy current entry into voice registers, gate on
// S_GATE_ON  | gate held high for on_ticks ticks
// S_GATE_OFF | gate released for off_ticks ticks
// S_DONE     | one cycle: release gate, pulse done, drop busy
module sid_note_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 50000,
  parameter int AW       = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rst_n,
  sid_note_sequencer_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_GATE_ON  = 3'd2;
  localparam logic [2:0] S_GATE_OFF = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic [63:0]   note_tbl [DEPTH];

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    on_cnt_q, on_cnt_d;
  logic [7:0]    off_cnt_q, off_cnt_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   freq_q, freq_d;
  logic [7:0]    dur_q, dur_d;
  logic [7:0]    att_q, att_d;
  logic [7:0]    sus_q, sus_d;
  logic [7:0]    wave_q, wave_d;
`ifdef SEQ_LOOP_EN
  logic          loop_q, loop_d;
`endif

  logic [63:0]   entry;
  logic          tick;
  logic          last_note;
  logic          next_note;

  // Table has no reset; a write to the entry being loaded lands after the read.
  always_ff @(posedge clk) begin
    if (bus.wr_en) note_tbl[bus.wr_addr] <= bus.wr_data;
  end

  assign entry     = note_tbl[idx_q];
  assign tick      = (tick_cnt_q == TICK_MAX);
  assign last_note = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    on_cnt_d   = on_cnt_q;
    off_cnt_d  = off_cnt_q;
    tick_cnt_d = tick_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    freq_d     = freq_q;
    dur_d      = dur_q;
    att_d      = att_q;
    sus_d      = sus_q;
    wave_d     = wave_q;
`ifdef SEQ_LOOP_EN
    loop_d     = loop_q;
`endif
    next_note  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.num_notes == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = (bus.num_notes > DEPTH_W) ? DEPTH_W : bus.num_notes;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = S_LOAD;
`ifdef SEQ_LOOP_EN
            loop_d  = bus.loop;
`endif
          end
        end
      end
      S_LOAD: begin
        freq_d    = entry[63:48];
        dur_d     = entry[47:40];
        att_d     = entry[39:32];
        sus_d     = entry[31:24];
        wave_d    = entry[23:16] | 8'h01;
        on_cnt_d  = (entry[15:8] == 8'd0) ? 8'd1 : entry[15:8];
        off_cnt_d = entry[7:0];
        state_d   = S_GATE_ON;
      end
      S_GATE_ON: begin
        if (tick) begin
          on_cnt_d = on_cnt_q - 8'd1;
          if (on_cnt_q == 8'd1) begin
            // Zero release time means legato: keep the gate up into the next note.
            if (off_cnt_q == 8'd0) begin
              next_note = 1'b1;
            end else begin
              wave_d[0] = 1'b0;
              state_d   = S_GATE_OFF;
            end
          end
        end
      end
      S_GATE_OFF: begin
        if (tick) begin
          off_cnt_d = off_cnt_q - 8'd1;
          if (off_cnt_q == 8'd1) next_note = 1'b1;
        end
      end
      S_DONE: begin
        wave_d[0] = 1'b0;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (next_note) begin
      if (last_note) begin
`ifdef SEQ_LOOP_EN
        if (loop_q) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end else begin
        idx_d   = idx_q + AW'(1);
        state_d = S_LOAD;
      end
    end

    if (bus.stop && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      wave_d[0] = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end

    // LOAD is only ever entered, never held, so state_d == S_LOAD marks entry.
    if (state_d == S_LOAD)
      tick_cnt_d = '0;
    else if ((state_q == S_LOAD) || (state_q == S_GATE_ON) || (state_q == S_GATE_OFF))
      tick_cnt_d = tick ? '0 : (tick_cnt_q + TW'(1));
    else
      tick_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      on_cnt_q   <= '0;
      off_cnt_q  <= '0;
      tick_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      freq_q     <= '0;
      dur_q      <= '0;
      att_q      <= '0;
      sus_q      <= '0;
      wave_q     <= '0;
`ifdef SEQ_LOOP_EN
      loop_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      on_cnt_q   <= on_cnt_d;
      off_cnt_q  <= off_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      freq_q     <= freq_d;
      dur_q      <= dur_d;
      att_q      <= att_d;
      sus_q      <= sus_d;
      wave_q     <= wave_d;
`ifdef SEQ_LOOP_EN
      loop_q     <= loop_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.note_idx  = idx_q;
  assign bus.frequency = freq_q;
  assign bus.duration  = dur_q;
  assign bus.attack    = att_q;
  assign bus.sustain   = sus_q;
  assign bus.waveform  = wave_q;

endmodule

// File: tb/tb_sid_note_sequencer.sv
// Randomized bench for sid_note_sequencer: traces each playback and scores it against note-level timing rules.
module tb_sid_note_sequencer;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int AW       = 2;
  localparam int MAXC     = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [63:0] tbl [DEPTH];

  int          tr_idx  [MAXC];
  logic        tr_gate [MAXC];
  logic        tr_busy [MAXC];
  logic [47:0] tr_fld  [MAXC];

  sid_note_sequencer_if #(.AW(AW)) bus ();

  sid_note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    longint d;
    checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic logic [63:0] ent(input int f, input int pw, input int at, input int su,
                                      input int wv, input int on, input int off);
    return {16'(f), 8'(pw), 8'(at), 8'(su), 8'(wv), 8'(on), 8'(off)};
  endfunction

  function automatic longint all_outs();
    return longint'({bus.busy, bus.done, bus.note_idx, bus.frequency, bus.duration,
                     bus.attack, bus.sustain, bus.waveform});
  endfunction

  task automatic wr(input int a, input logic [63:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    tbl[a] = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Score one note segment: gate timing from on/off ticks, voice fields from the table.
  task automatic check_seg(input int k, input int s, input int e);
    logic [63:0] en;
    logic [47:0] exp_fld;
    int on, off, hi, lo;
    if (k >= DEPTH) return;
    en = tbl[k];
    on = int'(en[15:8]);
    off = int'(en[7:0]);
    hi = 0;
    lo = 0;
    for (int c = s; c <= e; c++) begin
      if (tr_gate[c]) hi++;
      else lo++;
    end
    exp_fld = {en[63:48], en[47:40], en[39:32], en[31:24], en[23:16]};
    chk("seg_idx", tr_idx[s], k, 0);
    chk("gate_on_len", hi, ((on == 0) ? 1 : on) * TICK_DIV, 2);
    chk("gate_off_len", lo, off * TICK_DIV, 2);
    chk("note_fields", longint'(tr_fld[e][47:1]), longint'(exp_fld[47:1]), 0);
  endtask

  task automatic run_seq(input int n, input bit poke);
    int dc, exp_len, seg, seg_start, poke_at, busy_lo;
    bit seen;
    exp_len = (n > DEPTH) ? DEPTH : n;
    poke_at = poke ? int'($urandom_range(2, 20)) : -1;
    @(negedge clk);
    bus.num_notes = (AW+1)'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.num_notes = (AW+1)'($urandom);
    if (n == 0) begin
      chk("zero_done", bus.done, 1, 0);
      chk("zero_busy", bus.busy, 0, 0);
      @(negedge clk);
      chk("zero_done_pulse", bus.done, 0, 0);
      chk("zero_busy_after", bus.busy, 0, 0);
      return;
    end
    seen = 1'b0;
    dc = 0;
    for (int c = 0; c < MAXC; c++) begin
      tr_idx[c]  = int'(bus.note_idx);
      tr_gate[c] = bus.waveform[0];
      tr_busy[c] = bus.busy;
      tr_fld[c]  = {bus.frequency, bus.duration, bus.attack, bus.sustain, bus.waveform};
      if (bus.done) begin
        seen = 1'b1;
        dc = c;
        break;
      end
      if (c == poke_at) begin
        bus.start = 1'b1;
        bus.num_notes = (AW+1)'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_seen", seen, 1, 0);
    if (!seen) return;
    chk("done_busy_low", tr_busy[dc], 0, 0);
    chk("done_gate_low", tr_gate[dc], 0, 0);
    busy_lo = 0;
    for (int c = 0; c < dc; c++) if (!tr_busy[c]) busy_lo++;
    chk("busy_hold", busy_lo, 0, 0);
    seg = 0;
    seg_start = 0;
    for (int c = 1; c <= dc; c++) begin
      if (c == dc || tr_idx[c] != tr_idx[c-1]) begin
        check_seg(seg, seg_start, c - 1);
        seg++;
        seg_start = c;
      end
    end
    chk("note_count", seg, exp_len, 0);
    @(negedge clk);
    chk("done_single", bus.done, 0, 0);
  endtask

  initial begin
    int cnt;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.num_notes = '0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
`ifdef SEQ_LOOP_EN
    bus.loop = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 0, 0);

    // Single note, then three-note frequency staircase.
    wr(0, ent(148, 8'h80, 0, 8'h0F, 8'h40, 3, 2));
    run_seq(1, 1'b0);
    chk("freq_note0", bus.frequency, 148, 0);
    wr(1, ent(296, 8'h40, 5, 8'h0A, 8'h20, 2, 1));
    wr(2, ent(592, 8'h20, 9, 8'h05, 8'h10, 1, 3));
    run_seq(3, 1'b0);
    chk("freq_last", bus.frequency, 592, 0);
    chk("idx_last", bus.note_idx, 2, 0);

    // Legato boundary between note 0 and note 1.
    wr(0, ent(100, 1, 2, 3, 8'h40, 2, 0));
    wr(1, ent(200, 4, 5, 6, 8'h20, 2, 1));
    @(negedge clk);
    bus.num_notes = 3'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.note_idx != 2'd1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("legato_reach", bus.note_idx, 1, 0);
    chk("legato_gate", bus.waveform[0], 1, 0);
    @(negedge clk);
    chk("legato_gate_next", bus.waveform[0], 1, 0);
    chk("legato_freq", bus.frequency, 200, 0);
    cnt = 0;
    while (!bus.done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("legato_done", bus.done, 1, 0);

    // Stop during gate-on of note 1, with a simultaneous start that must lose.
    wr(0, ent(148, 1, 1, 1, 8'h40, 3, 2));
    wr(1, ent(296, 2, 2, 2, 8'h20, 3, 2));
    wr(2, ent(592, 3, 3, 3, 8'h10, 3, 2));
    @(negedge clk);
    bus.num_notes = 3'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (!(bus.note_idx == 2'd1 && bus.waveform[0]) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("stop_reach_note1", {bus.note_idx, bus.waveform[0]}, 3, 0);
    @(negedge clk);
    bus.stop = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.start = 1'b0;
    chk("stop_gate", bus.waveform[0], 0, 0);
    chk("stop_busy", bus.busy, 0, 0);
    chk("stop_done", bus.done, 0, 0);
    chk("stop_freq_hold", bus.frequency, 296, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) cnt++;
    end
    chk("stop_quiet", cnt, 0, 0);

    // Stop and start together in IDLE.
    bus.stop = 1'b1;
    bus.start = 1'b1;
    bus.num_notes = 3'd2;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.start = 1'b0;
    chk("stop_beats_start", {bus.busy, bus.done}, 0, 0);
    @(negedge clk);
    chk("stop_beats_start2", bus.busy, 0, 0);

    run_seq(2, 1'b0);
    run_seq(0, 1'b0);
    run_seq(DEPTH + 1, 1'b0);

    // Asynchronous reset in the middle of a note.
    @(negedge clk);
    bus.num_notes = 3'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_gate", bus.waveform[0], 1, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", all_outs(), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", all_outs(), 0, 0);

    // Random tables and note counts, with ignored start pulses mid-play.
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < DEPTH; a++)
        wr(a, {16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))});
      run_seq(int'($urandom_range(0, DEPTH + 1)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sid_note_sequencer.md
Name: sid_note_sequencer

Overview:
Plays a programmable table of notes into sid_top by driving its frequency, duration, attack, sustain and waveform configuration registers. Each entry sets a gate-on time, then a release time, both measured in coarse ticks. The block sits between the host/config logic and sid_top (sid_top -> pwm_audio chain unchanged) and replaces static register settings with a timed note sequence.

Parameters:
DEPTH, 16, number of note-table entries (power of 2, >=2)
TICK_DIV, 50000, clk cycles per sequencer tick (1 ms at 50 MHz); >=2
AW, $clog2(DEPTH), table address width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin playback at entry 0
stop  in  1  single-cycle pulse: abort playback, release gate
num_notes  in  AW+1  entries to play; sampled on accepted start
wr_en  in  1  note-table write strobe
wr_addr  in  AW  note-table write address
wr_data  in  64  entry {freq[63:48], pw[47:40], attack[39:32], sustain[31:24], wave[23:16], on_ticks[15:8], off_ticks[7:0]}
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse on normal completion or on num_notes==0 start
note_idx  out  AW  index of entry currently playing
frequency  out  16  to sid_top.frequency
duration  out  8  to sid_top.duration (pulse width)
attack  out  8  to sid_top.attack
sustain  out  8  to sid_top.sustain
waveform  out  8  to sid_top.waveform; bit0 = gate, owned by sequencer

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; tick counter 0; table contents undefined (not reset).
- Table: DEPTH x 64 regs, written on posedge when wr_en, in any state. Entry is read combinationally in LOAD; a same-cycle write to the loading address gives old data.
- Tick: counter runs 0..TICK_DIV-1 only outside IDLE/DONE; cleared on entering LOAD; tick=1 when counter==TICK_DIV-1.
- States: IDLE, LOAD, GATE_ON, GATE_OFF, DONE.
- IDLE: start && !stop -> if num_notes==0: done=1 next cycle, stay IDLE; else latch len=min(num_notes,DEPTH), idx=0, busy=1 -> LOAD.
- LOAD (1 cycle): drive frequency/duration/attack/sustain from entry; waveform = {wave[7:1],1}; on_cnt=max(on_ticks,1); off_cnt=off_ticks -> GATE_ON. Outputs update on exit edge of LOAD.
- GATE_ON: on tick, on_cnt--; when on_cnt reaches 0: if off_cnt==0 (legato) go directly to next-note decision with gate held 1; else waveform[0]<=0 -> GATE_OFF.
- GATE_OFF: on tick, off_cnt--; at 0 -> next-note decision.
- Next-note decision: idx==len-1 -> DONE; else idx++ -> LOAD.
- DONE (1 cycle): waveform[0]<=0 (legato last note also releases), done=1, busy=0 -> IDLE. Other registers hold last note.
- stop: any non-IDLE state -> IDLE next edge, waveform[0]<=0, busy=0, no done pulse; other outputs hold. stop beats start in the same cycle.
- start while busy ignored. num_notes changes after start ignored.
- Note latency: start at edge N -> gate=1 visible after edge N+2; gate-on lasts on_ticks*TICK_DIV cycles (±1).
- note_idx = idx; 0 in IDLE after reset, holds last value after completion.

Optional Feature:
SEQ_LOOP_EN: if defined, add input loop (1b, sampled at start). With loop=1, next-note decision at idx==len-1 wraps to idx=0 -> LOAD (no DONE, no done pulse), looping until stop. Without the macro, no loop port; sequence always ends in DONE.

Test Plan:
- TICK_DIV=4; entry0 {freq=148,pw=0x80,att=0,sus=0x0F,wave=0x40,on=3,off=2}, num_notes=1, start -> gate high 12 cycles (±1), low, done pulse after 8 more cycles, busy falls with done, frequency=148.
- Three entries with distinct freqs, num_notes=3 -> frequency steps 148,296,592; note_idx 0,1,2; exactly one done pulse.
- Entry off_ticks=0 on note 0 of 2 -> waveform[0] stays 1 across the note boundary; frequency changes without a gate gap.
- stop mid GATE_ON of note 1 -> next cycle gate=0, busy=0, no done, frequency holds note-1 value; later start restarts at idx 0.
- num_notes=0 start -> done one cycle, busy never high; num_notes=DEPTH+1 -> plays exactly DEPTH notes.
- rst_n low mid-note -> all outputs 0 immediately (asynchronous); SEQ_LOOP_EN with loop=1, 2 notes -> idx 0,1,0,1..., no done until stop.
